// File: rtl/charlie_pwm_scan.sv
// charlie_pwm_scan: charlieplexed LED scanner with per-slot PWM duty.
// Build option CHARLIE_BLANK_EN: insert DEAD blanking cycles before each slot.
module charlie_pwm_scan #(
  parameter  int PINS     = 8,
  parameter  int FRAMES   = 4,
  parameter  int PWM_BITS = 4,
  parameter  int DEAD     = 1,
  localparam int LEDS     = PINS * (PINS - 1),
  localparam int FSW      = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int SLOT     = 1 << PWM_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [FSW-1:0]         frame_sel,
  input  logic                   is_mirror,
  input  logic [PWM_BITS-1:0]    duty,
  input  logic [FRAMES*LEDS-1:0] memory_frame_buffer,
  output logic [PINS-1:0]        uio_out,
  output logic [PINS-1:0]        uio_oe,
  output logic [7:0]             led_index,
  output logic                   frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [7:0] PMAX = 8'(SLOT - 1);
  localparam logic [7:0] DMAX = 8'(DEAD - 1);
  localparam logic [7:0] KMAX = 8'(LEDS - 1);
  localparam logic [7:0] NCOL = 8'(PINS - 1);
  localparam int IW = (FRAMES * LEDS > 1) ? $clog2(FRAMES * LEDS) : 1;

  state_t              r_state, w_nx_state;
  logic [7:0]          r_k, w_nx_k;
  logic [7:0]          r_p, w_nx_p;
  logic                w_wrap, w_relatch;
  logic [FSW-1:0]      r_sel, w_nx_sel;
  logic                r_mir, w_nx_mir;
  logic [PWM_BITS-1:0] r_duty, w_nx_duty;
  logic [PINS-1:0]     r_out, r_oe;
  logic                r_fd;
  logic [7:0]          w_b, w_a, w_r, w_c;
  logic [IW-1:0]       w_idx;
  logic [PINS-1:0]     w_amask, w_cmask;
  logic                w_lit;

  always_comb begin
    w_nx_state = r_state;
    w_nx_k     = r_k;
    w_nx_p     = r_p;
    w_wrap     = 1'b0;
    w_relatch  = 1'b0;
    if (!enable) begin
      w_nx_state = IDLE;
      w_nx_k     = '0;
      w_nx_p     = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_relatch = 1'b1;
          w_nx_k    = '0;
          w_nx_p    = '0;
`ifdef CHARLIE_BLANK_EN
          w_nx_state = BLANK;
`else
          w_nx_state = DRIVE;
`endif
        end
        BLANK: begin
          if (r_p == DMAX) begin
            w_nx_state = DRIVE;
            w_nx_p     = '0;
          end else begin
            w_nx_p = r_p + 8'd1;
          end
        end
        DRIVE: begin
          if (r_p == PMAX) begin
            w_nx_p = '0;
`ifdef CHARLIE_BLANK_EN
            w_nx_state = BLANK;
`else
            w_nx_state = DRIVE;
`endif
            if (r_k == KMAX) begin
              w_nx_k    = '0;
              w_wrap    = 1'b1;
              w_relatch = 1'b1;
            end else begin
              w_nx_k = r_k + 8'd1;
            end
          end else begin
            w_nx_p = r_p + 8'd1;
          end
        end
        default: w_nx_state = IDLE;
      endcase
    end
  end

  // Display settings only change at a frame boundary (or on leaving IDLE).
  always_comb begin
    w_nx_sel  = r_sel;
    w_nx_mir  = r_mir;
    w_nx_duty = r_duty;
    if (w_relatch) begin
      w_nx_sel  = (int'(frame_sel) >= FRAMES) ? '0 : frame_sel;
      w_nx_mir  = is_mirror;
      w_nx_duty = duty;
    end
  end

  // Outputs are registered, so decode the slot we are about to enter.
  always_comb begin
    w_b     = w_nx_mir ? (KMAX - w_nx_k) : w_nx_k;
    w_idx   = IW'(int'(w_nx_sel) * LEDS + int'(w_b));
    w_a     = w_nx_k / NCOL;
    w_r     = w_nx_k % NCOL;
    w_c     = (w_r < w_a) ? w_r : (w_r + 8'd1);
    w_amask = PINS'(1) << w_a;
    w_cmask = PINS'(1) << w_c;
    w_lit   = (w_nx_state == DRIVE) &&
              memory_frame_buffer[w_idx] &&
              (w_nx_p < 8'(w_nx_duty));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_p     <= '0;
      r_sel   <= '0;
      r_mir   <= 1'b0;
      r_duty  <= '0;
      r_out   <= '0;
      r_oe    <= '0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_k     <= w_nx_k;
      r_p     <= w_nx_p;
      r_sel   <= w_nx_sel;
      r_mir   <= w_nx_mir;
      r_duty  <= w_nx_duty;
      r_out   <= w_lit ? w_amask : '0;
      r_oe    <= w_lit ? (w_amask | w_cmask) : '0;
      r_fd    <= w_wrap;
    end
  end

  assign uio_out    = r_out;
  assign uio_oe     = r_oe;
  assign led_index  = r_k;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_charlie_pwm_scan.sv
// tb_charlie_pwm_scan: directed checks of charlie_pwm_scan at PINS=4,
// PWM_BITS=2, DEAD=1, following whichever blanking build is compiled.
module tb_charlie_pwm_scan;

`ifdef CHARLIE_BLANK_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif
  localparam int S  = 4 + D;
  localparam int FP = 12 * S;

  // Hand-derived pin patterns for slots 0..11 with 4 pins.
  localparam logic [3:0] OE_T [12] = '{
    4'b0011, 4'b0101, 4'b1001,
    4'b0011, 4'b0110, 4'b1010,
    4'b0101, 4'b0110, 4'b1100,
    4'b1001, 4'b1010, 4'b1100
  };
  localparam logic [3:0] OUT_T [12] = '{
    4'b0001, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0010,
    4'b0100, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b1000
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  frame_sel;
  logic        is_mirror;
  logic [1:0]  duty;
  logic [47:0] fb;
  logic [3:0]  uio_out;
  logic [3:0]  uio_oe;
  logic [7:0]  led_index;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  charlie_pwm_scan #(
    .PINS(4), .FRAMES(4), .PWM_BITS(2), .DEAD(1)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .frame_sel           (frame_sel),
    .is_mirror           (is_mirror),
    .duty                (duty),
    .memory_frame_buffer (fb),
    .uio_out             (uio_out),
    .uio_oe              (uio_oe),
    .led_index           (led_index),
    .frame_done          (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input logic [7:0] k);
    chk({tag, ".oe"},  32'(uio_oe),     32'd0);
    chk({tag, ".out"}, 32'(uio_out),    32'd0);
    chk({tag, ".k"},   32'(led_index),  32'(k));
    chk({tag, ".fd"},  32'(frame_done), 32'd0);
  endtask

  // Walk frame positions t0..t1-1; position 0 is the first cycle of slot 0.
  task automatic check_frame(input string tag, input logic [11:0] mask,
                             input int nlit, input logic fd0,
                             input int t0, input int t1);
    int   k, ph;
    logic lit, fd;
    for (int t = t0; t < t1; t++) begin
      k   = t / S;
      ph  = t % S;
      lit = mask[k] && (ph >= D) && ((ph - D) < nlit);
      fd  = (t == 0) ? fd0 : 1'b0;
      chk($sformatf("%s.oe t=%0d", tag, t), 32'(uio_oe),
          lit ? 32'(OE_T[k]) : 32'd0);
      chk($sformatf("%s.out t=%0d", tag, t), 32'(uio_out),
          lit ? 32'(OUT_T[k]) : 32'd0);
      chk($sformatf("%s.k t=%0d", tag, t), 32'(led_index), 32'(k));
      chk($sformatf("%s.fd t=%0d", tag, t), 32'(frame_done), 32'(fd));
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    enable    = 1'b0;
    frame_sel = 2'd0;
    is_mirror = 1'b0;
    duty      = 2'd0;
    fb        = '0;

    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst_async", 8'd0);
    tick();
    tick();
    chk_zero("rst_held", 8'd0);

    // frame0: LED0; frame1: LED5; frame2: LED11
    fb[0]  = 1'b1;
    fb[17] = 1'b1;
    fb[35] = 1'b1;
    duty   = 2'd3;
    #1 rst_n = 1'b1;
    tick();
    chk_zero("idle_no_en", 8'd0);

    enable = 1'b1;
    tick();
    check_frame("f0a", 12'h001, 3, 1'b0, 0, FP);
    check_frame("f0b", 12'h001, 3, 1'b1, 0, FP);

    // Mid-frame changes must wait for the frame boundary.
    check_frame("f0c", 12'h001, 3, 1'b1, 0, 20);
    frame_sel = 2'd1;
    duty      = 2'd2;
    check_frame("f0d", 12'h001, 3, 1'b0, 20, FP);

    frame_sel = 2'd2;
    is_mirror = 1'b1;
    duty      = 2'd3;
    check_frame("f1", 12'h020, 2, 1'b1, 0, FP);

    check_frame("mir", 12'h001, 3, 1'b1, 0, D + 2);
    chk("mir_lit.oe", 32'(uio_oe), 32'b0011);
    chk("mir_lit.out", 32'(uio_out), 32'b0001);
    enable = 1'b0;
    tick();
    chk_zero("dis1", 8'd0);
    tick();
    tick();
    chk_zero("dis3", 8'd0);

    duty   = 2'd0;
    enable = 1'b1;
    tick();
    check_frame("duty0", 12'hfff, 0, 1'b0, 0, FP);

    enable = 1'b0;
    duty   = 2'd3;
    tick();
    chk_zero("dis_b", 8'd0);
    enable = 1'b1;
    tick();
    check_frame("pre_rst", 12'h001, 3, 1'b0, 0, D + 1);
    chk("pre_rst.oe", 32'(uio_oe), 32'b0011);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst_mid", 8'd0);
    #2 rst_n = 1'b1;
    tick();
    check_frame("post_rst", 12'h001, 3, 1'b0, 0, 2 * S);

    // Reset deeper in the frame must also clear the slot index.
    check_frame("deep", 12'h001, 3, 1'b0, 2 * S, 5 * S);
    chk("deep.k", 32'(led_index), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst_deep", 8'd0);
    #2 rst_n = 1'b1;
    tick();
    check_frame("restart", 12'h001, 3, 1'b0, 0, S);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/charlie_pwm_scan.md
CHARLIE_PWM_SCAN -- requirements
Module: charlie_pwm_scan

Interface
REQ-001 SHALL have parameter PINS, default 8; charlieplex pin count, 3..8; LEDS = PINS*(PINS-1).
REQ-002 SHALL have parameter FRAMES, default 4; frame buffer count, power of two, 1..8; FSW = max(1, log2(FRAMES)).
REQ-003 SHALL have parameter PWM_BITS, default 4; duty resolution, 1..8; SLOT = 2^PWM_BITS drive cycles.
REQ-004 SHALL have parameter DEAD, default 1; blanking cycles per slot, 1..7.
REQ-005 SHALL have port clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port enable, input, 1, scan run when high.
REQ-008 SHALL have port frame_sel, input, FSW, requested display frame.
REQ-009 SHALL have port is_mirror, input, 1, reverse LED order.
REQ-010 SHALL have port duty, input, PWM_BITS, global brightness.
REQ-011 SHALL have port memory_frame_buffer, input, FRAMES*LEDS; frame f, LED k at bit f*LEDS+k.
REQ-012 SHALL have port uio_out, output, PINS, pin drive levels.
REQ-013 SHALL have port uio_oe, output, PINS, pin enables, 1 = driven.
REQ-014 SHALL have port led_index, output, 8, current slot index k.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse at frame wrap.

Function
REQ-016 SHALL implement states IDLE, BLANK, DRIVE.
REQ-017 IDLE: uio_oe=0, uio_out=0, k=0; enable=1 -> BLANK, latching frame_sel, duty and is_mirror.
REQ-018 BLANK: lasts DEAD cycles with uio_oe=0, uio_out=0, then -> DRIVE with phase p=0.
REQ-019 DRIVE: lasts SLOT cycles, p = 0..SLOT-1, then -> BLANK with k+1.
REQ-020 Slot k pin mapping: anode a=k/(PINS-1), r=k%(PINS-1), cathode c = r<a ? r : r+1.
REQ-021 Lookup bit: b = is_mirror_latched ? LEDS-1-k : k, from frame frame_sel_latched.
REQ-022 Lit in DRIVE iff the lookup bit is 1 and p < duty_latched; lit -> uio_oe bits a,c = 1, uio_out bit a = 1, all else 0.
REQ-023 Unlit -> uio_oe=0, uio_out=0; no two LEDs are ever driven in the same cycle.
REQ-024 duty=0 -> never lit; duty=SLOT-1 -> lit SLOT-1 of SLOT cycles.
REQ-025 uio_out/uio_oe SHALL be registered; the lit window SHALL begin on the first DRIVE cycle of the slot.
REQ-026 After the last DRIVE cycle of k=LEDS-1: k wraps to 0, frame_done=1 for exactly that cycle, and frame_sel, duty and is_mirror are re-latched.
REQ-027 Changes to frame_sel, duty or is_mirror SHALL NOT take effect mid-frame (tear-free).
REQ-028 frame_sel >= FRAMES SHALL select frame 0.
REQ-029 enable=0 in any state -> IDLE on the next edge; outputs 0 from that edge on; no frame_done.
REQ-030 Frame period SHALL be LEDS*(DEAD+SLOT) cycles.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, k=0, p=0, uio_out=0, uio_oe=0, led_index=0, frame_done=0, and latched registers to 0, regardless of clk, including mid-DRIVE.
REQ-032 After rst_n release, the first transition SHALL occur on the first rising clk edge with enable=1.

Configuration
REQ-033 Macro CHARLIE_BLANK_EN defined: BLANK state with DEAD cycles as above.
REQ-034 CHARLIE_BLANK_EN undefined: BLANK is omitted, IDLE->DRIVE and DRIVE->DRIVE (k+1) directly, DEAD is ignored, and the frame period is LEDS*SLOT.

Verification (PINS=4, LEDS=12, PWM_BITS=2, SLOT=4, DEAD=1, CHARLIE_BLANK_EN defined)
REQ-035 Reset: rst_n=0 -> uio_oe=0000, uio_out=0000, led_index=0, frame_done=0.
REQ-036 Frame 0 bit0=1, duty=3, enable=1 -> 1 blank cycle, then oe=0011, out=0001 for 3 cycles, then 0000 for 1 cycle; frame_done pulses every 60 cycles.
REQ-037 Frame 0 bit5=1, duty=2 -> in slot k=5, oe=1010, out=0010 for 2 cycles; all other slots dark.
REQ-038 frame_sel 0->1 at cycle 20 of a frame -> frame 0 content is shown until frame_done, then frame 1.
REQ-039 is_mirror=1, only bit11=1, duty=3 -> lit in slot k=0 with oe=0011, out=0001; slot 11 dark.
REQ-040 rst_n low mid-DRIVE while lit -> oe/out 0000 asynchronously before the next clk edge; the scan restarts at k=0 after release.
